// File: rtl/afc_freq_comparator.sv
`default_nettype none
// ============================================================================
// Module   : afc_freq_comparator
// Brief    : Counts divided-VCO edges over a reference window and classifies
//            the count against target +/- tolerance as SLOW / FAST / FREEZE.
// Revision : 1.0 - initial release
// ============================================================================
module afc_freq_comparator #(
    parameter int CNT_W         = 8,
    parameter int SETTLE_CYCLES = 32,
    parameter int WIN_CYCLES    = 128
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             vco_div,
    input  logic             start,
    input  logic             change,
    input  logic [CNT_W-1:0] target_cnt,
    input  logic [CNT_W-1:0] tol_cnt,
    output logic [2:0]       comp_out,
    output logic             done,
    output logic             busy
);

    localparam int c_settle_w = $clog2(SETTLE_CYCLES + 1);
    localparam int c_win_w    = $clog2(WIN_CYCLES + 1);

    localparam logic [c_settle_w-1:0] c_settle_last = c_settle_w'(SETTLE_CYCLES - 1);
    localparam logic [c_settle_w-1:0] c_settle_one  = c_settle_w'(1);
    localparam logic [c_win_w-1:0]    c_win_last    = c_win_w'(WIN_CYCLES - 1);
    localparam logic [c_win_w-1:0]    c_win_one     = c_win_w'(1);
    localparam logic [CNT_W-1:0]      c_cnt_max     = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]      c_cnt_one     = CNT_W'(1);
    localparam logic [CNT_W:0]        c_cnt_max_x   = {1'b0, {CNT_W{1'b1}}};

    localparam logic [2:0] c_slow   = 3'b100;
    localparam logic [2:0] c_fast   = 3'b010;
    localparam logic [2:0] c_freeze = 3'b001;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SETTLE  = 2'd1,
        S_MEASURE = 2'd2,
        S_REPORT  = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic                  r_vco_s1;
    logic                  r_vco_s2;
    logic                  r_vco_s3;
    logic                  w_edge;
    logic [c_settle_w-1:0] r_settle_cnt;
    logic [c_win_w-1:0]    r_win_cnt;
    logic [CNT_W-1:0]      r_edge_cnt;
    logic [CNT_W-1:0]      w_edge_cnt_inc;
    logic                  w_settle_last;
    logic                  w_win_last;
    logic [2:0]            r_comp_out;
    logic                  r_done;

    logic [CNT_W:0]        w_target_x;
    logic [CNT_W:0]        w_tol_x;
    logic [CNT_W:0]        w_cnt_x;
    logic [CNT_W:0]        w_sum_x;
    logic [CNT_W:0]        w_lower_x;
    logic [CNT_W:0]        w_upper_x;
    logic [2:0]            w_result;

    // vco_div is asynchronous: two flops to resolve metastability, a third
    // to detect the rising edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vco_s1 <= 1'b0;
            r_vco_s2 <= 1'b0;
            r_vco_s3 <= 1'b0;
        end else begin
            r_vco_s1 <= vco_div;
            r_vco_s2 <= r_vco_s1;
            r_vco_s3 <= r_vco_s2;
        end
    end

    assign w_edge         = r_vco_s2 & ~r_vco_s3;
    assign w_settle_last  = (r_settle_cnt == c_settle_last);
    assign w_win_last     = (r_win_cnt == c_win_last);
    assign w_edge_cnt_inc = (w_edge && (r_edge_cnt != c_cnt_max)) ? (r_edge_cnt + c_cnt_one)
                                                                   : r_edge_cnt;

    // Bounds are formed one bit wider so target+tol cannot overflow and
    // target-tol can be clamped at zero instead of wrapping.
    assign w_target_x = {1'b0, target_cnt};
    assign w_tol_x    = {1'b0, tol_cnt};
    assign w_cnt_x    = {1'b0, r_edge_cnt};
    assign w_sum_x    = w_target_x + w_tol_x;
    assign w_lower_x  = (target_cnt >= tol_cnt) ? (w_target_x - w_tol_x) : '0;
    assign w_upper_x  = (w_sum_x > c_cnt_max_x) ? c_cnt_max_x : w_sum_x;

    always_comb begin
        w_result = c_freeze;
        if (w_cnt_x < w_lower_x) begin
            w_result = c_slow;
        end else if (w_cnt_x > w_upper_x) begin
            w_result = c_fast;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_next = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (change) begin
                    w_state_next = S_SETTLE;
                end else if (w_settle_last) begin
                    w_state_next = S_MEASURE;
                end
            end
            S_MEASURE: begin
                if (change) begin
                    w_state_next = S_SETTLE;
                end else if (w_win_last) begin
                    w_state_next = S_REPORT;
                end
            end
            S_REPORT: begin
                w_state_next = (w_result == c_freeze) ? S_IDLE : S_SETTLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Counters run only in their own state and clear everywhere else, so a
    // band change simply drops them back to zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_settle_cnt <= '0;
            r_win_cnt    <= '0;
            r_edge_cnt   <= '0;
            r_done       <= 1'b0;
            r_comp_out   <= 3'b000;
        end else begin
            if ((r_state == S_SETTLE) && !change && !w_settle_last) begin
                r_settle_cnt <= r_settle_cnt + c_settle_one;
            end else begin
                r_settle_cnt <= '0;
            end

            if ((r_state == S_MEASURE) && !change && !w_win_last) begin
                r_win_cnt <= r_win_cnt + c_win_one;
            end else begin
                r_win_cnt <= '0;
            end

            if ((r_state == S_MEASURE) && !change) begin
                r_edge_cnt <= w_edge_cnt_inc;
            end else begin
                r_edge_cnt <= '0;
            end

            r_done <= (r_state == S_REPORT);
            if (r_state == S_REPORT) begin
                r_comp_out <= w_result;
            end
        end
    end

    assign comp_out = r_comp_out;
    assign done     = r_done;
    assign busy     = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_afc_freq_comparator.sv
`default_nettype none
// ============================================================================
// Module   : tb_afc_freq_comparator
// Brief    : Directed scoreboard bench for afc_freq_comparator.
// Revision : 1.0 - initial release
// ============================================================================
module tb_afc_freq_comparator;

    localparam int c_settle  = 32;
    localparam int c_win     = 128;
    localparam int c_lat     = c_settle + c_win + 1;
    localparam int c_settle2 = 4;
    localparam int c_win2    = 600;
    localparam int c_lat2    = c_settle2 + c_win2 + 1;

    logic       clk = 1'b0;
    logic       rst;
    logic       vco_div;
    logic       start;
    logic       change;
    logic [7:0] target_cnt;
    logic [7:0] tol_cnt;
    logic [2:0] comp_out;
    logic       done;
    logic       busy;

    logic       vco2 = 1'b0;
    logic       start2;
    logic [7:0] target2;
    logic [7:0] tol2;
    logic [2:0] comp_out2;
    logic       done2;
    logic       busy2;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int period   = 0;

    typedef struct {
        int         cyc;
        logic [2:0] code;
    } exp_t;
    exp_t sb[$];

    afc_freq_comparator #(.CNT_W(8), .SETTLE_CYCLES(c_settle), .WIN_CYCLES(c_win)) u_dut (
        .clk(clk), .rst(rst), .vco_div(vco_div), .start(start), .change(change),
        .target_cnt(target_cnt), .tol_cnt(tol_cnt),
        .comp_out(comp_out), .done(done), .busy(busy)
    );

    afc_freq_comparator #(.CNT_W(8), .SETTLE_CYCLES(c_settle2), .WIN_CYCLES(c_win2)) u_dut_sat (
        .clk(clk), .rst(rst), .vco_div(vco2), .start(start2), .change(1'b0),
        .target_cnt(target2), .tol_cnt(tol2),
        .comp_out(comp_out2), .done(done2), .busy(busy2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Divided VCO with a programmable period in clk cycles (0 = held low).
    always begin
        if (period < 2) begin
            vco_div = 1'b0;
            @(posedge clk);
            #2;
        end else begin
            vco_div = 1'b1;
            repeat (period / 2) @(posedge clk);
            #2;
            vco_div = 1'b0;
            repeat (period / 2) @(posedge clk);
            #2;
        end
    end

    always begin
        @(posedge clk);
        #2;
        vco2 = ~vco2;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Every done strobe must match the oldest outstanding expectation.
    always @(posedge clk) begin
        #1;
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                chk("spurious_done", 32'(cyc), 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("done_cycle", 32'(cyc), 32'(e.cyc));
                chk("comp_out", {29'd0, comp_out}, {29'd0, e.code});
            end
        end
    end

    task automatic push(input int at, input logic [2:0] code);
        sb.push_back('{cyc: at, code: code});
    endtask

    task automatic start_pulse(output int e0);
        @(negedge clk);
        start = 1'b1;
        e0    = cyc + 1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_sb(input int left, input string tag);
        int n;
        n = 0;
        while (sb.size() > left && n < 2 * c_lat + 20) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(sb.size() > left), 32'd0);
    endtask

    task automatic wait_cyc(input int x);
        while (cyc < x) @(negedge clk);
    endtask

    task automatic run_freeze(input logic [7:0] tg, input logic [7:0] tl, input int per,
                              input string tag);
        int e0;
        target_cnt = tg;
        tol_cnt    = tl;
        period     = per;
        start_pulse(e0);
        push(e0 + c_lat, 3'b001);
        wait_sb(0, tag);
        @(negedge clk);
        chk({tag, "_idle"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int e0;
        int d;
        int n;

        rst        = 1'b1;
        start      = 1'b0;
        change     = 1'b0;
        target_cnt = '0;
        tol_cnt    = '0;
        start2     = 1'b0;
        target2    = 8'd250;
        tol2       = 8'd10;

        // Reset with random stimulus, including start
        repeat (3) begin
            @(negedge clk);
            chk("rst_comp_out", {29'd0, comp_out}, 32'd0);
            chk("rst_done", {31'd0, done}, 32'd0);
            chk("rst_busy", {31'd0, busy}, 32'd0);
            start      = 1'b1;
            change     = 1'($urandom);
            target_cnt = 8'($urandom);
            tol_cnt    = 8'($urandom);
        end
        @(negedge clk);
        rst    = 1'b0;
        start  = 1'b0;
        change = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_start_ignored", {31'd0, busy}, 32'd0);

        // SLOW twice, then FAST, then FREEZE
        target_cnt = 8'd32;
        tol_cnt    = 8'd2;
        period     = 8;
        start_pulse(e0);
        chk("busy_after_start", {31'd0, busy}, 32'd1);
        push(e0 + c_lat, 3'b100);
        push(e0 + 2 * c_lat, 3'b100);
        wait_sb(1, "slow1_timeout");
        chk("slow1_busy", {31'd0, busy}, 32'd1);
        wait_sb(0, "slow2_timeout");
        period = 2;
        push(e0 + 3 * c_lat, 3'b010);
        @(negedge clk);
        chk("slow2_busy_after", {31'd0, busy}, 32'd1);
        wait_sb(0, "fast_timeout");
        period = 4;
        push(e0 + 4 * c_lat, 3'b001);
        @(negedge clk);
        chk("fast_busy_after", {31'd0, busy}, 32'd1);
        wait_sb(0, "freeze_timeout");
        @(negedge clk);
        chk("freeze_idle", {31'd0, busy}, 32'd0);
        chk("comp_out_hold", {29'd0, comp_out}, 32'd1);

        // change 50 cycles into MEASURE, then change in the last MEASURE cycle
        period = 8;
        start_pulse(e0);
        d = e0 + c_settle + 50 + c_lat;
        push(d, 3'b100);
        wait_cyc(e0 + c_settle + 49);
        change = 1'b1;
        @(negedge clk);
        change = 1'b0;
        wait_sb(0, "chg_mid_timeout");
        wait_cyc(d + c_settle + c_win - 1);
        change = 1'b1;
        period = 4;
        push(d + c_settle + c_win + c_lat, 3'b001);
        @(negedge clk);
        change = 1'b0;
        wait_sb(0, "chg_last_timeout");
        @(negedge clk);
        chk("chg_last_idle", {31'd0, busy}, 32'd0);

        // Bounds: exact hit, count on upper bound, on lower bound, clamped lower
        run_freeze(8'd32, 8'd0, 4, "tol0");
        run_freeze(8'd30, 8'd2, 4, "upper_eq");
        run_freeze(8'd34, 8'd2, 4, "lower_eq");
        run_freeze(8'd1, 8'd5, 0, "lower_clamp");

        // Saturation: 300 edges in the long window must stick at 255
        @(negedge clk);
        start2 = 1'b1;
        e0     = cyc + 1;
        @(negedge clk);
        start2 = 1'b0;
        n = 0;
        while (done2 !== 1'b1 && n < c_lat2 + 50) begin
            @(negedge clk);
            n++;
        end
        chk("sat_cycle", 32'(cyc), 32'(e0 + c_lat2));
        chk("sat_code", {29'd0, comp_out2}, 32'd1);
        @(negedge clk);
        chk("sat_idle", {31'd0, busy2}, 32'd0);

        // Reset during MEASURE aborts with no report
        target_cnt = 8'd32;
        tol_cnt    = 8'd2;
        period     = 4;
        start_pulse(e0);
        wait_cyc(e0 + 99);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_done", {31'd0, done}, 32'd0);
        chk("midrst_comp_out", {29'd0, comp_out}, 32'd0);
        rst = 1'b0;
        wait_cyc(e0 + c_lat + 20);
        chk("midrst_still_idle", {31'd0, busy}, 32'd0);

        // start while busy must not disturb the timing
        start_pulse(e0);
        push(e0 + c_lat, 3'b001);
        wait_cyc(e0 + 9);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_cyc(e0 + 60);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_sb(0, "busy_start_timeout");
        @(negedge clk);
        chk("busy_start_idle", {31'd0, busy}, 32'd0);

        repeat (5) @(negedge clk);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
